// File: rtl/multi_serial_out.sv
// multi_serial_out: NUM_CH independent serial pattern generators.
// Each channel shifts out a latched DATA_BIT-wide pattern one bit at a time.
// Every bit is held for the channel's fast or slow period, chosen per bit by
// a latched frequency pattern. Channels support counted or continuous
// repeats, back-to-back frames with no gap, and a per-channel idle level.
// Optional build macro: SERIAL_OUT_MSB_FIRST_EN shifts MSB first instead of
// LSB first. Ports and timing are the same in both builds.
module multi_serial_out #(
    parameter int NUM_CH   = 4,
    parameter int DATA_BIT = 32,
    parameter int PERIOD_W = 8,
    parameter int RPT_W    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH-1:0]            start_i,
    input  logic [NUM_CH-1:0]            stop_i,
    input  logic [NUM_CH*RPT_W-1:0]      repeat_i,
    input  logic [NUM_CH-1:0]            idle_level_i,
    input  logic [NUM_CH*DATA_BIT-1:0]   output_pattern_i,
    input  logic [NUM_CH*DATA_BIT-1:0]   freq_pattern_i,
    input  logic [NUM_CH*PERIOD_W-1:0]   slow_period_i,
    input  logic [NUM_CH*PERIOD_W-1:0]   fast_period_i,
    output logic [NUM_CH-1:0]            serial_out_o,
    output logic [NUM_CH-1:0]            busy_o,
    output logic [NUM_CH-1:0]            bit_tick_o,
    output logic [NUM_CH-1:0]            frame_tick_o,
    output logic [NUM_CH-1:0]            done_tick_o
);

    localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

`ifdef SERIAL_OUT_MSB_FIRST_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(DATA_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = '0;

    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx);
        return idx - IDX_W'(1);
    endfunction
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BIT - 1);

    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction
`endif

    // Down-counter load value for a bit: selected period minus one, with a
    // zero period treated as a one-cycle bit.
    function automatic logic [PERIOD_W-1:0] load_val(
        input logic                sel_fast,
        input logic [PERIOD_W-1:0] fast,
        input logic [PERIOD_W-1:0] slow
    );
        logic [PERIOD_W-1:0] p;
        p = sel_fast ? fast : slow;
        return (p == '0) ? '0 : p - PERIOD_W'(1);
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e              state_q;
        logic [DATA_BIT-1:0] pat_q;
        logic [DATA_BIT-1:0] freq_q;
        logic [PERIOD_W-1:0] fast_q;
        logic [PERIOD_W-1:0] slow_q;
        logic [PERIOD_W-1:0] tmr_q;
        logic [RPT_W-1:0]    rpt_q;
        logic [RPT_W-1:0]    left_q;
        logic [IDX_W-1:0]    idx_q;
        logic                idle_q;
        logic                sout_q;
        logic                busy_q;

        logic [DATA_BIT-1:0] pat_in;
        logic [DATA_BIT-1:0] freq_in;
        logic [PERIOD_W-1:0] fast_in;
        logic [PERIOD_W-1:0] slow_in;
        logic [RPT_W-1:0]    rpt_in;

        logic                last_bit;
        logic                more_frames;
        logic                last_cyc;
        logic [IDX_W-1:0]    idx_d;
        logic [PERIOD_W-1:0] tmr_d;

        assign pat_in  = output_pattern_i[c*DATA_BIT +: DATA_BIT];
        assign freq_in = freq_pattern_i[c*DATA_BIT +: DATA_BIT];
        assign fast_in = fast_period_i[c*PERIOD_W +: PERIOD_W];
        assign slow_in = slow_period_i[c*PERIOD_W +: PERIOD_W];
        assign rpt_in  = repeat_i[c*RPT_W +: RPT_W];

        assign last_bit    = (idx_q == LAST_IDX);
        // Another frame follows when running continuously or frames remain.
        assign more_frames = (rpt_q == '0) || (left_q > RPT_W'(1));
        // Final cycle of the current bit; an incoming start/stop aborts it,
        // so no ticks are reported for that cycle.
        assign last_cyc    = (state_q == S_RUN) && (tmr_q == '0)
                             && !start_i[c] && !stop_i[c];

        // Wrap to the first bit at frame end so the next frame starts seamlessly.
        assign idx_d = last_bit ? FIRST_IDX : step_idx(idx_q);
        assign tmr_d = load_val(freq_q[idx_d], fast_q, slow_q);

        // Channel FSM: stop beats start, start (re)latches configuration,
        // otherwise count down the current bit and advance through the frame.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= S_IDLE;
                pat_q   <= '0;
                freq_q  <= '0;
                fast_q  <= '0;
                slow_q  <= '0;
                tmr_q   <= '0;
                rpt_q   <= '0;
                left_q  <= '0;
                idx_q   <= '0;
                idle_q  <= 1'b0;
                sout_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else if (stop_i[c]) begin
                if (state_q == S_RUN) begin
                    state_q <= S_IDLE;
                    sout_q  <= idle_q;
                    busy_q  <= 1'b0;
                end
            end else if (start_i[c]) begin
                state_q <= S_RUN;
                pat_q   <= pat_in;
                freq_q  <= freq_in;
                fast_q  <= fast_in;
                slow_q  <= slow_in;
                rpt_q   <= rpt_in;
                left_q  <= rpt_in;
                idle_q  <= idle_level_i[c];
                idx_q   <= FIRST_IDX;
                tmr_q   <= load_val(freq_in[FIRST_IDX], fast_in, slow_in);
                sout_q  <= pat_in[FIRST_IDX];
                busy_q  <= 1'b1;
            end else if (state_q == S_RUN) begin
                if (tmr_q != '0) begin
                    tmr_q <= tmr_q - PERIOD_W'(1);
                end else if (last_bit && !more_frames) begin
                    state_q <= S_IDLE;
                    sout_q  <= idle_q;
                    busy_q  <= 1'b0;
                end else begin
                    if (last_bit && (rpt_q != '0)) begin
                        left_q <= left_q - RPT_W'(1);
                    end
                    idx_q  <= idx_d;
                    tmr_q  <= tmr_d;
                    sout_q <= pat_q[idx_d];
                end
            end
        end

        assign serial_out_o[c] = sout_q;
        assign busy_o[c]       = busy_q;
        assign bit_tick_o[c]   = last_cyc;
        assign frame_tick_o[c] = last_cyc && last_bit;
        assign done_tick_o[c]  = last_cyc && last_bit && !more_frames;
    end

endmodule

// File: tb/tb_multi_serial_out.sv
// Testbench for multi_serial_out (NUM_CH=2, DATA_BIT=8).
// Table of channel-0 configurations expanded by a bit-level model into a
// per-cycle expectation queue, plus hand-written multi-cycle sequences.
module tb_multi_serial_out;

    localparam int NC = 2;
    localparam int DB = 8;
    localparam int PW = 8;
    localparam int RW = 8;

`ifdef SERIAL_OUT_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [NC-1:0]    start_i, stop_i, idle_level_i;
    logic [NC*RW-1:0] repeat_i;
    logic [NC*DB-1:0] output_pattern_i, freq_pattern_i;
    logic [NC*PW-1:0] slow_period_i, fast_period_i;
    logic [NC-1:0]    serial_out_o, busy_o, bit_tick_o, frame_tick_o, done_tick_o;

    multi_serial_out #(.NUM_CH(NC), .DATA_BIT(DB), .PERIOD_W(PW), .RPT_W(RW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .repeat_i        (repeat_i),
        .idle_level_i    (idle_level_i),
        .output_pattern_i(output_pattern_i),
        .freq_pattern_i  (freq_pattern_i),
        .slow_period_i   (slow_period_i),
        .fast_period_i   (fast_period_i),
        .serial_out_o    (serial_out_o),
        .busy_o          (busy_o),
        .bit_tick_o      (bit_tick_o),
        .frame_tick_o    (frame_tick_o),
        .done_tick_o     (done_tick_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] freq;
        logic [7:0] fast;
        logic [7:0] slow;
        logic [7:0] rpt;
        logic       idle;
    } vec_t;

    // Observed/expected per-cycle view of one channel.
    typedef struct packed {
        logic sout;
        logic busy;
        logic bt;
        logic ft;
        logic dt;
    } obs_t;

    obs_t sb[$];
    int   nvec  = 0;
    int   nfail = 0;
    logic idle_exp = 1'b0;
    vec_t v1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic obs_t sample0();
        obs_t o;
        o.sout = serial_out_o[0];
        o.busy = busy_o[0];
        o.bt   = bit_tick_o[0];
        o.ft   = frame_tick_o[0];
        o.dt   = done_tick_o[0];
        return o;
    endfunction

    task automatic drive_cfg(input int ch, input vec_t v);
        output_pattern_i[ch*DB +: DB] = v.pat;
        freq_pattern_i[ch*DB +: DB]   = v.freq;
        fast_period_i[ch*PW +: PW]    = v.fast;
        slow_period_i[ch*PW +: PW]    = v.slow;
        repeat_i[ch*RW +: RW]         = v.rpt;
        idle_level_i[ch]              = v.idle;
    endtask

    // Expand a finite-repeat configuration into expected per-cycle records,
    // ending with one idle cycle.
    task automatic model_push(input vec_t v);
        int   nfr;
        obs_t e;
        nfr = int'(v.rpt);
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < DB; b++) begin
                int i;
                int p;
                i = MSB ? (DB - 1 - b) : b;
                p = v.freq[i] ? int'(v.fast) : int'(v.slow);
                if (p == 0) p = 1;
                for (int k = 0; k < p; k++) begin
                    e.sout = v.pat[i];
                    e.busy = 1'b1;
                    e.bt   = (k == p - 1);
                    e.ft   = e.bt && (b == DB - 1);
                    e.dt   = e.ft && (f == nfr - 1);
                    sb.push_back(e);
                end
            end
        end
        e = '{sout: v.idle, busy: 1'b0, bt: 1'b0, ft: 1'b0, dt: 1'b0};
        sb.push_back(e);
    endtask

    // Compare channel 0 against the queue, one record per cycle. Optionally
    // exercise channel 1 (start 3 cycles in, stop at cycle 20) meanwhile.
    task automatic drain(input bit with_ch1);
        int   n;
        obs_t e;
        n = 0;
        while (sb.size() > 0 && n < 3000) begin
            n++;
            if (with_ch1) begin
                if (n == 3) begin drive_cfg(1, v1); start_i[1] = 1'b1; end
                if (n == 4) start_i[1] = 1'b0;
                if (n == 20) stop_i[1] = 1'b1;
                if (n == 21) stop_i[1] = 1'b0;
            end
            #1;
            e = sb.pop_front();
            check("sb_ch0", sample0(), e);
            if (with_ch1 && n == 10) check("ch1_busy_run", busy_o[1], 1);
            if (with_ch1 && n == 21) check("ch1_stopped", {serial_out_o[1], busy_o[1]}, {v1.idle, 1'b0});
            @(posedge clk_i); #1;
        end
        if (sb.size() > 0) begin
            check("sb_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_ch0(input vec_t v);
        model_push(v);
        drive_cfg(0, v);
        start_i[0] = 1'b1;
        #1;
        check("pre_idle", sample0(), {idle_exp, 4'b0000});
        @(posedge clk_i); #1;
        start_i[0] = 1'b0;
        drain(1'b0);
        idle_exp = v.idle;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        vec_t        va, vb, ve;
        logic [23:0] seq, ftv, dtv, seq_exp;
        int          bts, fts, dts, ones, lowbusy;

        tbl[0] = '{pat: 8'hA5, freq: 8'h0F, fast: 8'd2, slow: 8'd4, rpt: 8'd1, idle: 1'b0};
        tbl[1] = '{pat: 8'hA5, freq: 8'h0F, fast: 8'd2, slow: 8'd4, rpt: 8'd3, idle: 1'b0};
        tbl[2] = '{pat: 8'h3C, freq: 8'hF0, fast: 8'd0, slow: 8'd1, rpt: 8'd1, idle: 1'b1};
        tbl[3] = '{pat: 8'h96, freq: 8'hAA, fast: 8'd3, slow: 8'd1, rpt: 8'd2, idle: 1'b1};
        tbl[4] = '{pat: 8'hC3, freq: 8'h55, fast: 8'd1, slow: 8'd0, rpt: 8'd1, idle: 1'b0};
        v1     = '{pat: 8'h5A, freq: 8'h33, fast: 8'd1, slow: 8'd3, rpt: 8'd0, idle: 1'b1};

        rst_ni = 1'b0;
        start_i = '0; stop_i = '0; idle_level_i = '0; repeat_i = '0;
        output_pattern_i = '0; freq_pattern_i = '0; slow_period_i = '0; fast_period_i = '0;
        #3;
        check("reset_outs", {serial_out_o, busy_o, bit_tick_o, frame_tick_o, done_tick_o}, 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Literal timing of the reference frame.
        drive_cfg(0, tbl[0]);
        start_i[0] = 1'b1;
        @(posedge clk_i); #1;
        start_i[0] = 1'b0;
        seq = '0; ftv = '0; dtv = '0; bts = 0;
        for (int n = 1; n <= 25; n++) begin
            #1;
            if (n <= 24) begin
                seq = {seq[22:0], serial_out_o[0]};
                ftv = {ftv[22:0], frame_tick_o[0]};
                dtv = {dtv[22:0], done_tick_o[0]};
                bts += int'(bit_tick_o[0]);
            end else begin
                check("t1_after", {serial_out_o[0], busy_o[0]}, 2'b00);
            end
            @(posedge clk_i); #1;
        end
        seq_exp = MSB ? 24'b111100001111000000110011 : 24'b110011000000111100001111;
        check("t1_seq", seq, seq_exp);
        check("t1_bitticks", bts, 8);
        check("t1_frame", ftv, 24'h000001);
        check("t1_done", dtv, 24'h000001);

        // Table of configurations through the scoreboard.
        for (int t = 0; t < 5; t++) run_ch0(tbl[t]);

        // Continuous run, then stop mid-bit.
        va = '{pat: 8'h0F, freq: 8'h00, fast: 8'd7, slow: 8'd3, rpt: 8'd0, idle: 1'b1};
        drive_cfg(0, va);
        start_i[0] = 1'b1;
        @(posedge clk_i); #1;
        start_i[0] = 1'b0;
        fts = 0; dts = 0; lowbusy = 0;
        for (int n = 1; n <= 60; n++) begin
            #1;
            fts += int'(frame_tick_o[0]);
            dts += int'(done_tick_o[0]);
            lowbusy += int'(!busy_o[0]);
            @(posedge clk_i); #1;
        end
        check("cont_frames", fts, 2);
        check("cont_busy", lowbusy, 0);
        stop_i[0] = 1'b1;
        #1;
        dts += int'(done_tick_o[0]);
        check("stop_midbit_out", serial_out_o[0], 0);
        @(posedge clk_i); #1;
        stop_i[0] = 1'b0;
        #1;
        check("stop_idle", {serial_out_o[0], busy_o[0]}, 2'b10);
        check("cont_no_done", dts, 0);
        idle_exp = 1'b1;
        @(posedge clk_i); #1;

        // Restart in the middle of a frame.
        va = '{pat: 8'hFF, freq: 8'h00, fast: 8'd7, slow: 8'd2, rpt: 8'd0, idle: 1'b0};
        vb = '{pat: 8'h00, freq: 8'h00, fast: 8'd7, slow: 8'd2, rpt: 8'd1, idle: 1'b0};
        drive_cfg(0, va);
        start_i[0] = 1'b1;
        @(posedge clk_i); #1;
        start_i[0] = 1'b0;
        ones = 0;
        for (int n = 1; n <= 9; n++) begin
            #1;
            ones += int'(serial_out_o[0]);
            @(posedge clk_i); #1;
        end
        check("restart_pre_ones", ones, 9);
        drive_cfg(0, vb);
        start_i[0] = 1'b1;
        #1;
        check("restart_no_ftick", {serial_out_o[0], frame_tick_o[0], done_tick_o[0]}, 3'b100);
        model_push(vb);
        @(posedge clk_i); #1;
        start_i[0] = 1'b0;
        drain(1'b0);
        idle_exp = 1'b0;

        // start and stop together while idle: nothing happens.
        va = '{pat: 8'hFF, freq: 8'hFF, fast: 8'd1, slow: 8'd1, rpt: 8'd1, idle: 1'b1};
        drive_cfg(0, va);
        start_i[0] = 1'b1;
        stop_i[0]  = 1'b1;
        @(posedge clk_i); #1;
        start_i[0] = 1'b0;
        stop_i[0]  = 1'b0;
        #1;
        check("startstop_idle", {serial_out_o[0], busy_o[0]}, {idle_exp, 1'b0});
        @(posedge clk_i); #1;
        check("startstop_idle2", {serial_out_o[0], busy_o[0]}, {idle_exp, 1'b0});

        // Channel 0 unaffected by channel 1 activity.
        ve = '{pat: 8'hA5, freq: 8'h0F, fast: 8'd2, slow: 8'd4, rpt: 8'd2, idle: 1'b0};
        model_push(ve);
        drive_cfg(0, ve);
        start_i[0] = 1'b1;
        @(posedge clk_i); #1;
        start_i[0] = 1'b0;
        drain(1'b1);
        idle_exp = ve.idle;

        // Asynchronous reset in the middle of a frame on both channels.
        ve.rpt = 8'd0;
        drive_cfg(0, ve);
        drive_cfg(1, v1);
        start_i = 2'b11;
        @(posedge clk_i); #1;
        start_i = 2'b00;
        repeat (5) @(posedge clk_i);
        #3;
        check("pre_rst_busy", busy_o, 2'b11);
        rst_ni = 1'b0;
        #1;
        check("async_rst_outs", {serial_out_o, busy_o, bit_tick_o, frame_tick_o, done_tick_o}, 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #2;
        check("post_rst_idle", {serial_out_o, busy_o}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/multi_serial_out.md
Name: multi_serial_out

Overview:
Multi-channel successor to the single-channel serial pattern generator. NUM_CH independent channels each shift out a DATA_BIT-wide pattern LSB first. Each bit is held for the channel's fast or slow period, selected per bit by a frequency pattern. Adds counted repeats, seamless back-to-back frames, per-channel idle level and a busy flag. Sits between the register/UART command decoder and the pad drivers.

Parameters:
NUM_CH, 4, number of independent output channels
DATA_BIT, 32, pattern length in bits (2..64)
PERIOD_W, 8, width of period fields
RPT_W, 8, width of repeat count (0 = continuous)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  NUM_CH  per-channel start/restart pulse; latches that channel's configuration
stop_i  in  NUM_CH  per-channel abort; has priority over start_i
repeat_i  in  NUM_CH*RPT_W  frame count per channel; 0 = run until stop
idle_level_i  in  NUM_CH  output level while idle, latched at start
output_pattern_i  in  NUM_CH*DATA_BIT  data pattern; channel c uses slice [c*DATA_BIT +: DATA_BIT]
freq_pattern_i  in  NUM_CH*DATA_BIT  per-bit select; 1 = fast period, 0 = slow period
slow_period_i  in  NUM_CH*PERIOD_W  slow bit duration in clocks
fast_period_i  in  NUM_CH*PERIOD_W  fast bit duration in clocks
serial_out_o  out  NUM_CH  registered serial data
busy_o  out  NUM_CH  high while the channel is in RUN
bit_tick_o  out  NUM_CH  one-cycle pulse in the last cycle of every bit
frame_tick_o  out  NUM_CH  one-cycle pulse in the last cycle of every frame
done_tick_o  out  NUM_CH  one-cycle pulse in the last cycle of the final frame only

Behaviour:
- Reset: all outputs 0; every channel in IDLE; all latched configuration and counters cleared.
- Channels are fully independent. The description below is per channel.
- States are IDLE and RUN. No intermediate DONE state: frames run back to back with no gap cycle.
- IDLE:
  - serial_out_o = latched idle level; busy_o = 0.
  - When start_i=1 and stop_i=0 at edge k: latch pattern, freq, both periods, repeat and idle level.
  - Bit index is set to 0 and the state moves to RUN.
  - From cycle k+1: serial_out_o = pattern bit 0 and busy_o = 1.
- Bit timing:
  - Each bit is held for exactly P clocks. P is the fast or slow period selected by the latched freq bit.
  - A period value of 0 is treated as 1.
  - The down-counter is loaded with P-1; the bit advances when the counter reaches 0.
  - bit_tick_o is high in that final cycle of the bit.
- End of frame, meaning the last cycle of bit DATA_BIT-1:
  - frame_tick_o = 1 in that cycle.
  - If the latched repeat is 0, or the remaining-frame count is greater than 1: decrement the count (never when repeat is 0), reset the index to 0, and start bit 0 in the next cycle with no idle gap.
  - Otherwise: done_tick_o = 1 in the same cycle, the state moves to IDLE, and serial_out_o returns to the idle level in the next cycle.
- Frame length in clocks is the sum of the per-bit periods.
- Restart: start_i in RUN (with stop_i=0) re-latches all configuration and restarts at bit 0 in the next cycle. No frame_tick_o or done_tick_o is generated for the aborted frame.
- Stop: stop_i in RUN moves to IDLE in the next cycle with output at the idle level. No done_tick_o. stop_i in IDLE is ignored.
- Inputs are sampled only at start. Changes to input patterns during RUN have no effect until the next start.
- Bit index width is clog2(DATA_BIT). The index never exceeds DATA_BIT-1.
- An asynchronous reset asserted mid-frame forces all outputs to 0 immediately. Nothing is resumed after reset.

Optional Feature:
SERIAL_OUT_MSB_FIRST_EN
- Defined: bit order is reversed. The index starts at DATA_BIT-1 and counts down to 0. The freq bit selecting each period is taken at the same index. The end of frame occurs at index 0.
- Undefined: LSB first, as described above.
- Ports and timing are identical in both builds.

Test Plan:
1. Timing, ch0 (NUM_CH=2, DATA_BIT=8). Stimulus: pattern 8'hA5, freq 8'h0F, fast=2, slow=4, repeat=1, idle=0. Required: serial_out_o sequence 1,1,0,0,1,1,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1 (24 cycles). 8 bit_tick_o pulses. frame_tick_o and done_tick_o both high in cycle 24. Output 0 and busy_o=0 from cycle 25.
2. Repeat and continuous. Stimulus: repeat=3. Required: 72 contiguous run cycles, 3 frame_tick_o pulses, 1 done_tick_o pulse. Stimulus: repeat=0. Required: runs indefinitely with no done_tick_o; stop_i mid-bit gives idle level next cycle and no done_tick_o.
3. Restart. Stimulus: start_i with pattern 8'hFF at run cycle 10, then 8'h00. Required: output 0 from the next cycle, bit index at 0, no frame_tick_o for the aborted frame.
4. Boundaries and priority. Stimulus: fast=0, slow=1. Required: every bit lasts 1 cycle, frame = 8 cycles. Stimulus: start_i and stop_i together in IDLE. Required: stays IDLE. Stimulus: idle=1. Required: serial_out_o=1 before and after the run.
5. Channel independence. Stimulus: ch0 and ch1 started 3 cycles apart with different periods; stop ch1 while ch0 is running. Required: ch0 sequence and ticks unchanged versus running alone.
6. Reset and optional feature. Stimulus: rst_ni low mid-frame. Required: all outputs 0 asynchronously, IDLE on release. With SERIAL_OUT_MSB_FIRST_EN defined, case 1 required sequence starts 1,1,1,1 (bit 7, slow period).
